// File: rtl/kf_keyboard_pkg.sv
// rtl/kf_keyboard_pkg.sv - shared types and constants for the XT keyboard receiver
package kf_keyboard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } kb_state_e;

    localparam logic KB_START_BIT = 1'b1;
    localparam int   KB_DATA_BITS = 8;

endpackage

// File: rtl/kf_kb_input_filter.sv
// rtl/kf_kb_input_filter.sv - pad synchroniser, level glitch filter and registered fall pulse
module kf_kb_input_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pad_i,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q;
    logic                   fall_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // A differing sample must persist FILTER_LEN cycles; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= {SYNC_STAGES{RESET_VAL}};
            cnt_q      <= '0;
            filt_q     <= RESET_VAL;
            filt_dly_q <= RESET_VAL;
            fall_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_i};
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fall_q     <= filt_dly_q & ~filt_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/kf_xt_keyboard_receiver.sv
// rtl/kf_xt_keyboard_receiver.sv - XT keyboard frame receiver feeding KF8255 port A and IRQ1
module kf_xt_keyboard_receiver
    import kf_keyboard_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       kb_clock_in,
    input  logic       kb_data_in,
    output logic       kb_clock_drive_low,
    input  logic       clear_keyboard,
    input  logic       clock_enable,
    output logic [7:0] scancode,
    output logic       irq,
    output logic       frame_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    kb_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        timeout_q, timeout_d;
    logic [7:0]             scancode_q, scancode_d;
    logic                   irq_q, irq_d;
    logic                   frame_error_q, frame_error_d;
    logic                   kb_fall;
    logic                   kb_data;

    kf_kb_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .RESET_VAL   (1'b1)
    ) u_clk_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .pad_i   (kb_clock_in),
        .fall_o  (kb_fall)
    );

    assign kb_data = data_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_sync_q   <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            timeout_q     <= '0;
            scancode_q    <= '0;
            irq_q         <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], kb_data_in};
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            timeout_q     <= timeout_d;
            scancode_q    <= scancode_d;
            irq_q         <= irq_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Clear dominates everything, including a final-bit edge landing in the same cycle.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        timeout_d     = timeout_q;
        scancode_d    = scancode_q;
        irq_d         = irq_q;
        frame_error_d = 1'b0;
        if (clear_keyboard) begin
            state_d    = IDLE;
            scancode_d = '0;
            irq_d      = 1'b0;
            bit_cnt_d  = '0;
            timeout_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kb_fall && (kb_data == KB_START_BIT)) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        timeout_d = '0;
                    end
                end
                SHIFT: begin
                    if (kb_fall) begin
                        shreg_d   = {kb_data, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        timeout_d = '0;
                        if (bit_cnt_q == 3'(KB_DATA_BITS - 1)) begin
                            state_d    = FULL;
                            scancode_d = {kb_data, shreg_q[7:1]};
                            irq_d      = 1'b1;
                        end
                    end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d       = IDLE;
                        frame_error_d = 1'b1;
                        timeout_d     = '0;
                        bit_cnt_d     = '0;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
                FULL: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding the keyboard clock low during reset keeps the keyboard from sending into a dead receiver.
    always_comb begin
        kb_clock_drive_low = ~reset_n | (state_q == FULL) | ~clock_enable;
    end

    assign scancode    = scancode_q;
    assign irq         = irq_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_kf_xt_keyboard_receiver.sv
// tb/tb_kf_xt_keyboard_receiver.sv - directed scoreboard bench for kf_xt_keyboard_receiver
module tb_kf_xt_keyboard_receiver;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 4096;
    localparam int LAT            = SYNC_STAGES + FILTER_LEN + 2;
    localparam int HALF           = 12;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       kb_clock_in = 1'b1;
    logic       kb_data_in = 1'b0;
    logic       kb_clock_drive_low;
    logic       clear_keyboard = 1'b0;
    logic       clock_enable = 1'b1;
    logic [7:0] scancode;
    logic       irq;
    logic       frame_error;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    kf_xt_keyboard_receiver #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .kb_clock_in        (kb_clock_in),
        .kb_data_in         (kb_data_in),
        .kb_clock_drive_low (kb_clock_drive_low),
        .clear_keyboard     (clear_keyboard),
        .clock_enable       (clock_enable),
        .scancode           (scancode),
        .irq                (irq),
        .frame_error        (frame_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: scoreboard frame, 1: clear on final edge, 2: unchecked traffic
    task automatic send_bit(input logic b, input int mode, input bit last, input bit glitch);
        logic [7:0] e;
        kb_data_in = b;
        if (glitch) begin
            repeat (HALF / 2) @(negedge clock);
            kb_clock_in = 1'b0;
            repeat (2) @(negedge clock);
            kb_clock_in = 1'b1;
            repeat (HALF - HALF / 2 - 2) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        kb_clock_in = 1'b0;
        if (last && mode == 0) begin
            repeat (LAT - 1) @(negedge clock);
            check("irq_before_latency", irq, 1'b0);
            @(negedge clock);
            check("irq_at_latency", irq, 1'b1);
            check("drive_low_full", kb_clock_drive_low, 1'b1);
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("scancode", scancode, e);
            end
        end else if (last && mode == 1) begin
            repeat (LAT - 1) @(negedge clock);
            clear_keyboard = 1'b1;
            @(negedge clock);
            clear_keyboard = 1'b0;
            check("collide_irq", irq, 1'b0);
            check("collide_scancode", scancode, 8'h00);
            check("collide_drive_low", kb_clock_drive_low, 1'b0);
        end
        repeat (HALF) @(negedge clock);
        kb_clock_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input int nbits, input int mode, input int glitch_bit);
        if (mode == 0) exp_q.push_back(code);
        send_bit(1'b1, mode, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(code[i], mode, i == 7, i == glitch_bit);
        end
    endtask

    task automatic pulse_clear();
        clear_keyboard = 1'b1;
        @(negedge clock);
        clear_keyboard = 1'b0;
        check("clear_scancode", scancode, 8'h00);
        check("clear_irq", irq, 1'b0);
        check("clear_drive_low", kb_clock_drive_low, 1'b0);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int n;
        bit found;

        #1;
        check("rst_drive_low", kb_clock_drive_low, 1'b1);
        check("rst_scancode", scancode, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("idle_drive_low", kb_clock_drive_low, 1'b0);

        send_frame(8'h1C, 8, 0, -1);
        send_frame(8'h55, 8, 2, -1);
        check("full_holds_scancode", scancode, 8'h1C);
        check("full_holds_irq", irq, 1'b1);
        pulse_clear();
        send_frame(8'h9C, 8, 0, -1);
        pulse_clear();

        send_frame(8'hA5, 4, 2, -1);
        check("partial_invisible", scancode, 8'h00);
        n = 0;
        found = 1'b0;
        while (n < TIMEOUT_CYCLES + 200 && !found) begin
            @(negedge clock);
            n++;
            if (frame_error) found = 1'b1;
        end
        check("timeout_seen", found, 1'b1);
        @(negedge clock);
        check("ferr_single_pulse", frame_error, 1'b0);
        check("timeout_scancode", scancode, 8'h00);
        check("timeout_irq", irq, 1'b0);
        check("timeout_drive_low", kb_clock_drive_low, 1'b0);
        send_frame(8'h3B, 8, 0, -1);
        pulse_clear();

        kb_clock_in = 1'b0;
        repeat (2) @(negedge clock);
        kb_clock_in = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h2A, 8, 0, 4);
        pulse_clear();

        send_frame(8'h55, 8, 1, -1);
        repeat (10) @(negedge clock);
        check("collide_stays_idle", irq, 1'b0);
        send_frame(8'h12, 8, 0, -1);
        pulse_clear();

        clock_enable = 1'b0;
        #1;
        check("clk_en_drive_low", kb_clock_drive_low, 1'b1);
        clock_enable = 1'b1;
        #1;
        check("clk_en_release", kb_clock_drive_low, 1'b0);
        @(negedge clock);

        send_frame(8'hFF, 3, 2, -1);
        reset_n = 1'b0;
        #1;
        check("async_rst_drive_low", kb_clock_drive_low, 1'b1);
        check("async_rst_scancode", scancode, 8'h00);
        check("async_rst_irq", irq, 1'b0);
        check("async_rst_ferr", frame_error, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h81, 8, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
